// File: rtl/master_port.sv
// Master-side bus port: takes one strobed request from a master, presents it to the crossbar
// while granted, then returns one completion pulse carrying read data or a timeout error.
module master_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_from_master,
  input  logic [ADDR_W-1:0] addr_from_master,
  input  logic [DATA_W-1:0] wdata_from_master,
  input  logic              cmd_from_master,
  output logic              ack_to_master,
  output logic [DATA_W-1:0] rdata_to_master,
  output logic              err_to_master,
  output logic              busy,
  output logic              req_to_crossbar,
  output logic [ADDR_W-1:0] addr_to_crossbar,
  output logic [DATA_W-1:0] wdata_to_crossbar,
  output logic              cmd_to_crossbar,
  input  logic              ack_from_crossbar,
  input  logic [DATA_W-1:0] rdata_from_crossbar,
  input  logic              connect_approved_from_crossbar
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cmd;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_qual_ack;
  logic w_timeout;
  logic w_gate;
  logic w_resp;

  assign w_qual_ack = ack_from_crossbar & connect_approved_from_crossbar;
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cmd   <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_from_master) begin
            r_addr  <= addr_from_master;
            r_wdata <= wdata_from_master;
            r_cmd   <= cmd_from_master;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // A qualified ack wins over a timeout landing in the same cycle.
          if (w_qual_ack) begin
            r_rdata <= r_cmd ? '0 : rdata_from_crossbar;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_gate = (r_state == S_REQ) && connect_approved_from_crossbar;
  assign w_resp = (r_state == S_RESP);

  assign req_to_crossbar   = (r_state == S_REQ);
  assign busy              = (r_state != S_IDLE);
  assign addr_to_crossbar  = w_gate ? r_addr  : '0;
  assign wdata_to_crossbar = w_gate ? r_wdata : '0;
  assign cmd_to_crossbar   = w_gate & r_cmd;
  assign ack_to_master     = w_resp;
  assign rdata_to_master   = w_resp ? r_rdata : '0;
  assign err_to_master     = w_resp & r_err;

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port (TIMEOUT=4): table-driven transactions with a response scoreboard,
// plus hand-written reset and strobe-collision sequences.
module tb_master_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        cmd_m;
  logic        ack_m;
  logic [31:0] rdata_m;
  logic        err_m;
  logic        busy;
  logic        req_x;
  logic [31:0] addr_x;
  logic [31:0] wdata_x;
  logic        cmd_x;
  logic        ack_x;
  logic [31:0] rdata_x;
  logic        grant;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  master_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .req_from_master                (req_m),
    .addr_from_master               (addr_m),
    .wdata_from_master              (wdata_m),
    .cmd_from_master                (cmd_m),
    .ack_to_master                  (ack_m),
    .rdata_to_master                (rdata_m),
    .err_to_master                  (err_m),
    .busy                           (busy),
    .req_to_crossbar                (req_x),
    .addr_to_crossbar               (addr_x),
    .wdata_to_crossbar              (wdata_x),
    .cmd_to_crossbar                (cmd_x),
    .ack_from_crossbar              (ack_x),
    .rdata_from_crossbar            (rdata_x),
    .connect_approved_from_crossbar (grant)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ack_m === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack_to_master=1 expected no transaction (t=%0t)", $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", rdata_m, e[31:0]);
        chk("resp_err", err_m, e[32]);
        $display("txn done: rdata=%h err=%0d", rdata_m, err_m);
      end
    end
  end

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          gdelay;
    int          adelay;
    logic        spur;
    logic        restrobe;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  // Starts at a negedge in IDLE, ends at the negedge of the IDLE cycle after RESP.
  task automatic run_vec(input vec_t v);
    int q;
    int n;
    q = v.gdelay + v.adelay;
    n = (q <= 3) ? q + 1 : 4;
    req_m = 1'b1; addr_m = v.addr; wdata_m = v.wdata; cmd_m = v.cmd;
    exp_q.push_back({v.exp_err, v.exp_rd});
    @(posedge clk); #1;
    req_m = 1'b0; addr_m = '0; wdata_m = '0; cmd_m = 1'b0;
    for (int k = 0; k < n; k++) begin
      grant   = (k >= v.gdelay);
      ack_x   = (k >= q) || (v.spur && k < v.gdelay);
      rdata_x = v.rd;
      if (v.restrobe && k == 0) begin
        req_m = 1'b1; addr_m = 32'hFFFF_0000; wdata_m = 32'h5A5A_5A5A; cmd_m = ~v.cmd;
      end
      @(negedge clk);
      chk("req_to_xbar", req_x, 1);
      chk("busy_req", busy, 1);
      chk("ack_in_req", ack_m, 0);
      chk("addr_gate", addr_x, grant ? v.addr : 32'h0);
      chk("wdata_gate", wdata_x, grant ? v.wdata : 32'h0);
      chk("cmd_gate", cmd_x, grant ? v.cmd : 1'b0);
      @(posedge clk); #1;
      req_m = 1'b0; addr_m = '0; wdata_m = '0; cmd_m = 1'b0;
    end
    grant = 1'b0; ack_x = 1'b0; rdata_x = '0;
    @(negedge clk);
    chk("ack_latency", ack_m, 1);
    chk("req_in_resp", req_x, 0);
    chk("busy_resp", busy, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("ack_idle", ack_m, 0);
    chk("rdata_idle", rdata_m, 0);
    chk("err_idle", err_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cmd  addr          wdata         rd            gd  ad  spur restrb err exp_rd
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0,  0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'hAAAA_5555, 3,  0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,        32'hCAFE_F00D, 0, 10, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,        32'h1111_2222, 2,  0, 1'b1, 1'b0, 1'b0, 32'h1111_2222};
    vecs[4] = '{1'b1, 32'h0000_0050, 32'h7777_8888, 32'h9999_0000, 10, 0, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0060, 32'h0,        32'h0BAD_C0DE, 1,  1, 1'b0, 1'b1, 1'b0, 32'h0BAD_C0DE};
    vecs[6] = '{1'b0, 32'h0000_0070, 32'h0,        32'h1357_9BDF, 3,  0, 1'b0, 1'b0, 1'b0, 32'h1357_9BDF};

    rst = 1'b1; req_m = 1'b0; addr_m = '0; wdata_m = '0; cmd_m = 1'b0;
    ack_x = 1'b0; rdata_x = '0; grant = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req_x", req_x, 0);
    chk("rst_ack", ack_m, 0);
    chk("rst_rdata", rdata_m, 0);
    chk("rst_err", err_m, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      $display("vector %0d: cmd=%0d addr=%h", i, vecs[i].cmd, vecs[i].addr);
      run_vec(vecs[i]);
    end

    // Reset while in REQ with a qualified ack pending: transaction aborts silently.
    req_m = 1'b1; addr_m = 32'h80; cmd_m = 1'b0;
    @(posedge clk); #1;
    req_m = 1'b1; rst = 1'b1; grant = 1'b1; ack_x = 1'b1; rdata_x = 32'hFEED_FACE;
    @(negedge clk);
    chk("req_before_rst", req_x, 1);
    @(posedge clk); #1;
    rst = 1'b0; req_m = 1'b0; ack_x = 1'b0;
    @(negedge clk);
    chk("rst_abort_busy", busy, 0);
    chk("rst_abort_req", req_x, 0);
    chk("rst_abort_ack", ack_m, 0);
    chk("rst_abort_addr", addr_x, 0);
    chk("rst_abort_cmd", cmd_x, 0);
    grant = 1'b0; rdata_x = '0;
    $display("reset-in-REQ sequence done");
    run_vec(vecs[0]);

    // Reset and strobe in the same cycle: reset wins.
    rst = 1'b1; req_m = 1'b1; addr_m = 32'h90;
    @(posedge clk); #1;
    rst = 1'b0; req_m = 1'b0; addr_m = '0;
    @(negedge clk);
    chk("rst_dominates", busy, 0);
    @(negedge clk);
    chk("rst_dominates_2", busy, 0);
    $display("reset-with-strobe sequence done");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of all write-data and read-data ports.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum number of REQ-state cycles before error; 0 SHALL disable the timeout.
REQ-004 One clock, clk; reset rst, synchronous, active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_from_master  in  1  single-cycle request strobe from master.
REQ-008 addr_from_master  in  ADDR_W  request address.
REQ-009 wdata_from_master  in  DATA_W  write data.
REQ-010 cmd_from_master  in  1  1 = write, 0 = read.
REQ-011 ack_to_master  out  1  one-cycle completion pulse.
REQ-012 rdata_to_master  out  DATA_W  read data, valid with ack_to_master.
REQ-013 err_to_master  out  1  timeout flag, valid with ack_to_master.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 req_to_crossbar  out  1  request to crossbar.
REQ-016 addr_to_crossbar  out  ADDR_W  captured address, gated by grant.
REQ-017 wdata_to_crossbar  out  DATA_W  captured write data, gated by grant.
REQ-018 cmd_to_crossbar  out  1  captured command, gated by grant.
REQ-019 ack_from_crossbar  in  1  slave completion via crossbar.
REQ-020 rdata_from_crossbar  in  DATA_W  slave read data.
REQ-021 connect_approved_from_crossbar  in  1  arbitration grant for this port.

Function
REQ-022 FSM SHALL have three states: IDLE, REQ and RESP.
REQ-023 In IDLE with req_from_master=1, the block SHALL capture addr, wdata and cmd into registers and move to REQ on the next edge.
REQ-024 req_from_master SHALL be ignored in REQ and RESP, with no queueing.
REQ-025 req_to_crossbar SHALL equal (state==REQ) and SHALL be driven directly from the state register.
REQ-026 addr/wdata/cmd_to_crossbar SHALL equal the captured values when state==REQ and connect_approved_from_crossbar=1, and SHALL be all-zero otherwise.
REQ-027 In REQ, ack_from_crossbar=1 AND connect_approved_from_crossbar=1 SHALL move the FSM to RESP.
REQ-028 On that transition, the block SHALL register rdata_from_crossbar for a read, or zero for a write, and SHALL set err=0.
REQ-029 ack_from_crossbar without connect_approved_from_crossbar SHALL be ignored.
REQ-030 Loss of grant mid-REQ SHALL zero the gated outputs and keep req_to_crossbar high.
REQ-031 Timeout counter SHALL clear on IDLE->REQ and increment each REQ cycle without a qualified ack.
REQ-032 When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no qualified ack, the FSM SHALL move to RESP with err=1 and rdata=0.
REQ-033 A qualified ack in the timeout cycle SHALL take priority, giving err=0.
REQ-034 Counter width SHALL be clog2(TIMEOUT+1), with a minimum of 1, and SHALL never wrap.
REQ-035 In RESP, ack_to_master SHALL be 1 for exactly one cycle, with rdata_to_master and err_to_master valid; the FSM SHALL return to IDLE on the next edge.
REQ-036 Outside RESP, ack_to_master, err_to_master and rdata_to_master SHALL all be 0.
REQ-037 Latency: strobe at cycle N, grant+ack at N+1, SHALL give ack_to_master at N+2; the next strobe SHALL be accepted at N+3.
REQ-038 busy SHALL be 0 only in IDLE, so a master may strobe when busy=0.

Reset
REQ-039 rst=1 at a clock edge SHALL force IDLE and clear captured registers, counter, rdata and err; all outputs SHALL be 0 the cycle after.
REQ-040 rst asserted mid-REQ or mid-RESP SHALL abort the transaction without ack_to_master; rst SHALL dominate req_from_master in the same cycle.

Verification
REQ-041 Read, immediate grant: strobe addr=0x0000_0010 read; grant+ack with rdata=0xDEAD_BEEF one cycle later -> ack_to_master 2 cycles after strobe, rdata=0xDEAD_BEEF, err=0.
REQ-042 Delayed grant: write addr=0x20 wdata=0x1234_5678; grant held low 3 cycles -> addr/wdata/cmd_to_crossbar read 0 while req_to_crossbar=1; on grant they read 0x20/0x1234_5678/1; ack -> ack_to_master, rdata=0.
REQ-043 Timeout: TIMEOUT=4, never ack -> ack_to_master=1 with err=1 and rdata=0 exactly 4 REQ cycles after entry; a qualified ack on the 4th cycle -> err=0 instead.
REQ-044 Ungranted ack: ack_from_crossbar=1 while connect_approved_from_crossbar=0 -> no state change; a later qualified ack completes normally.
REQ-045 Ignored strobe and reset: strobe during REQ -> no second transaction; rst during REQ -> busy=0, all outputs 0, no ack_to_master; a strobe the following cycle is accepted.
